// File: rtl/sseg_mux_ctrl_if.sv
// Signal bundle between a value source and the multiplexed seven-segment
// controller.
//   value/dp_in/load   : hex nibbles and decimal points, captured on load
//   digit_en/blank_lz  : live per-digit enables and leading-zero blanking
//   brightness         : PWM duty, all-ones = always on
//   sseg_anode/cathode : active-low display pins
//   digit_idx          : digit currently scanned
//   frame_tick         : one-cycle pulse at each frame start
// master = value source side, slave = controller side.
interface sseg_mux_ctrl_if #(
  parameter int NUM_DIGITS = 8,
  parameter int BRIGHT_W   = 4
) ();
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    blank_lz;
  logic [BRIGHT_W-1:0]     brightness;
  logic [NUM_DIGITS-1:0]   sseg_anode;
  logic [7:0]              sseg_cathode;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_tick;

  modport master (
    output value, dp_in, load, digit_en, blank_lz, brightness,
    input  sseg_anode, sseg_cathode, digit_idx, frame_tick
  );

  modport slave (
    input  value, dp_in, load, digit_en, blank_lz, brightness,
    output sseg_anode, sseg_cathode, digit_idx, frame_tick
  );
endinterface

// File: rtl/sseg_mux_ctrl.sv
// Parametrised N-digit multiplexed seven-segment display controller.
// Scans one digit per CLK_DIV-cycle slot with hex decode, per-digit decimal
// points and enables, leading-zero blanking, PWM brightness, anti-ghosting
// dead time and frame-synchronous (tear-free) value updates.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : sseg_mux_ctrl_if slave modport (inputs, anode/cathode outputs,
//           digit_idx, frame_tick)
module sseg_mux_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int CLK_DIV     = 5000,
  parameter int DEAD_CYCLES = 50,
  parameter int BRIGHT_W    = 4
) (
  input  logic            clk,
  input  logic            reset,
  sseg_mux_ctrl_if.slave  bus
);
  localparam int PH_W  = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [PH_W-1:0]  PHASE_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  DEAD_END   = PH_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [PH_W-1:0]       phase;
  logic [IDX_W-1:0]      digit_idx;
  logic [BRIGHT_W-1:0]   pwm_cnt;
  logic                  frame_tick;
  logic [VAL_W-1:0]      stage_val, shadow_val;
  logic [NUM_DIGITS-1:0] stage_dp, shadow_dp;
  logic                  pending;
  logic [NUM_DIGITS-1:0] anode;
  logic [7:0]            cathode;

  logic                  slot_end, frame_end;
  logic [3:0]            cur_nib;
  logic                  cur_dp, cur_blank;
  logic [6:0]            cur_seg;
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  zero_above;
  logic [NUM_DIGITS-1:0] anode_next;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign slot_end  = (phase == PHASE_LAST);
  assign frame_end = slot_end && (digit_idx == IDX_LAST);

  // lead_zero[d]: shadow nibbles NUM_DIGITS-1 down to d are all zero.
  always_comb begin
    lead_zero  = '0;
    zero_above = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      zero_above = zero_above && (shadow_val[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
      lead_zero[NUM_DIGITS-1-i] = zero_above;
    end
  end

  always_comb begin
    cur_nib    = '0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    anode_next = '1;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (digit_idx == IDX_W'(d)) begin
        cur_nib   = shadow_val[4*d +: 4];
        cur_dp    = shadow_dp[d];
        cur_blank = bus.blank_lz && lead_zero[d] && (d != 0);
        if (bus.digit_en[d] && (phase >= DEAD_END) && (pwm_cnt <= bus.brightness))
          anode_next[d] = 1'b0;
      end
    end
    cur_seg = cur_blank ? 7'h7F : hex7(cur_nib);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase      <= '0;
      digit_idx  <= '0;
      pwm_cnt    <= '0;
      frame_tick <= 1'b0;
      stage_val  <= '0;
      stage_dp   <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      anode      <= '1;
      cathode    <= '1;
    end else begin
      phase      <= slot_end ? '0 : phase + 1'b1;
      pwm_cnt    <= pwm_cnt + 1'b1;
      frame_tick <= frame_end;
      if (slot_end)
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;

      if (bus.load) begin
        stage_val <= bus.value;
        stage_dp  <= bus.dp_in;
      end

      // A load coinciding with the frame boundary bypasses staging so it
      // lands in the frame that is just starting.
      if (frame_end) begin
        pending <= 1'b0;
        if (bus.load) begin
          shadow_val <= bus.value;
          shadow_dp  <= bus.dp_in;
        end else if (pending) begin
          shadow_val <= stage_val;
          shadow_dp  <= stage_dp;
        end
      end else if (bus.load) begin
        pending <= 1'b1;
      end

      anode   <= anode_next;
      cathode <= {~cur_dp, cur_seg};
    end
  end

  assign bus.sseg_anode   = anode;
  assign bus.sseg_cathode = cathode;
  assign bus.digit_idx    = digit_idx;
  assign bus.frame_tick   = frame_tick;
endmodule

// File: tb/tb_sseg_mux_ctrl.sv
// Directed bench for sseg_mux_ctrl with NUM_DIGITS=4, CLK_DIV=8,
// DEAD_CYCLES=2, BRIGHT_W=2. Expected cathode patterns are hand-decoded.
module tb_sseg_mux_ctrl;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_err;

  sseg_mux_ctrl_if #(.NUM_DIGITS(4), .BRIGHT_W(2)) bus ();

  sseg_mux_ctrl #(
    .NUM_DIGITS (4),
    .CLK_DIV    (8),
    .DEAD_CYCLES(2),
    .BRIGHT_W   (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.frame_tick) break;
    end
    check("frame_tick_seen", {31'd0, bus.frame_tick}, 32'd1);
  endtask

  // Called while sampling a frame_tick cycle. Checks one full frame; sample i
  // reflects slot i/8, phase i%8, pwm i%4. Optionally loads at iteration
  // load_at (captured at the next edge; 30 hits the frame boundary edge).
  task automatic run_frame(input string name, input logic [31:0] cats,
                           input int load_at, input logic [15:0] lval,
                           input logic [3:0] ldp, input logic [1:0] bright,
                           input logic [3:0] en);
    int s, p;
    logic [3:0] exp_an;
    bus.brightness = bright;
    bus.digit_en   = en;
    for (int i = 0; i < 32; i++) begin
      tick();
      s = i / 8;
      p = i % 8;
      exp_an = 4'hF;
      if (en[s] && p >= 2 && (p % 4) <= int'(bright)) exp_an[s] = 1'b0;
      check($sformatf("%s_cath_%0d", name, i), {24'd0, bus.sseg_cathode}, {24'd0, cats[8*s +: 8]});
      check($sformatf("%s_anode_%0d", name, i), {28'd0, bus.sseg_anode}, {28'd0, exp_an});
      check($sformatf("%s_tick_%0d", name, i), {31'd0, bus.frame_tick}, (i == 31) ? 32'd1 : 32'd0);
      check($sformatf("%s_idx_%0d", name, i), {30'd0, bus.digit_idx}, ((i + 1) / 8) % 4);
      if (i == load_at) begin
        bus.load  = 1'b1;
        bus.value = lval;
        bus.dp_in = ldp;
      end else begin
        bus.load = 1'b0;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    reset          = 1'b1;
    bus.value      = '0;
    bus.dp_in      = '0;
    bus.load       = 1'b0;
    bus.digit_en   = 4'hF;
    bus.blank_lz   = 1'b0;
    bus.brightness = 2'd3;

    tick();
    tick();
    check("rst_anode", {28'd0, bus.sseg_anode}, 32'hF);
    check("rst_cath", {24'd0, bus.sseg_cathode}, 32'hFF);
    check("rst_idx", {30'd0, bus.digit_idx}, 32'd0);
    check("rst_tick", {31'd0, bus.frame_tick}, 32'd0);
    reset = 1'b0;

    // Free-run after release: k counts edges since release.
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) begin
        check("first_cath", {24'd0, bus.sseg_cathode}, 32'hC0);
        check("first_anode", {28'd0, bus.sseg_anode}, 32'hF);
      end
      if (k == 3) check("dead_end_anode", {28'd0, bus.sseg_anode}, 32'hE);
      check($sformatf("hold_idx_%0d", k), {30'd0, bus.digit_idx}, (k / 8) % 4);
      check($sformatf("hold_tick_%0d", k), {31'd0, bus.frame_tick}, (k % 32 == 0) ? 32'd1 : 32'd0);
    end

    bus.load  = 1'b1;
    bus.value = 16'h3A5F;
    bus.dp_in = 4'h0;
    tick();
    bus.load = 1'b0;
    wait_tick();

    // 3A5F shown; a mid-frame load of 1234 must wait for the next frame.
    run_frame("f3a5f", 32'hB088928E, 10, 16'h1234, 4'h0, 2'd3, 4'hF);
    bus.blank_lz = 1'b1;
    // 1234 shown; boundary load of 0050 appears in the very next frame.
    run_frame("f1234", 32'hF9A4B099, 30, 16'h0050, 4'h0, 2'd3, 4'hF);
    run_frame("f0050", 32'hFFFF92C0, 30, 16'h0000, 4'h0, 2'd3, 4'hF);
    run_frame("f0000", 32'hFFFFFFC0, 30, 16'h0000, 4'h8, 2'd3, 4'hF);
    run_frame("fdp3", 32'h7FFFFFC0, 30, 16'h3A5F, 4'h2, 2'd3, 4'hF);
    run_frame("fpwm", 32'hB088128E, -1, 16'h0000, 4'h0, 2'd1, 4'hB);

    // Pending load interrupted by a mid-slot asynchronous reset.
    bus.brightness = 2'd3;
    bus.digit_en   = 4'hF;
    bus.load       = 1'b1;
    bus.value      = 16'h9999;
    bus.dp_in      = 4'hF;
    tick();
    bus.load = 1'b0;
    tick();
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("async_anode", {28'd0, bus.sseg_anode}, 32'hF);
    check("async_cath", {24'd0, bus.sseg_cathode}, 32'hFF);
    check("async_idx", {30'd0, bus.digit_idx}, 32'd0);
    bus.blank_lz = 1'b0;
    tick();
    check("held_cath", {24'd0, bus.sseg_cathode}, 32'hFF);
    reset = 1'b0;
    tick();
    check("post_rst_cath", {24'd0, bus.sseg_cathode}, 32'hC0);
    wait_tick();
    run_frame("fpostrst", 32'hC0C0C0C0, -1, 16'h0000, 4'h0, 2'd3, 4'hF);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/sseg_mux_ctrl.md
# sseg_mux_ctrl

Parametrised N-digit multiplexed seven-segment display controller. It replaces the fixed four-digit chain of divider, refresh counter, anode control, BCD select and cathode decode with one block. It adds full hex decode, per-digit decimal points and enables, leading-zero blanking, PWM brightness, anti-ghosting dead time and tear-free frame-synchronous value updates. It sits between the value source (switches, counters) and the board anode/cathode pins.

## Interface
- NUM_DIGITS, 8: digits scanned, 2..16
- CLK_DIV, 5000: clk cycles per digit slot (50 MHz → 10 kHz slot rate); ≥ 4
- DEAD_CYCLES, 50: anodes forced off at the start of each slot; must be < CLK_DIV
- BRIGHT_W, 4: brightness / PWM counter width
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- value  in  4*NUM_DIGITS  hex nibbles; nibble d drives digit d (digit 0 is least significant)
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit; captured with value
- load  in  1  capture value/dp_in into staging
- digit_en  in  NUM_DIGITS  live per-digit enable; 0 = anode never driven
- blank_lz  in  1  leading-zero suppression
- brightness  in  BRIGHT_W  PWM duty; all-ones = 100 %
- sseg_anode  out  NUM_DIGITS  active-low
- sseg_cathode  out  8  active-low; bit 7 = dp, bits 6:0 = g,f,e,d,c,b,a
- digit_idx  out  clog2(NUM_DIGITS)  digit currently scanned
- frame_tick  out  1  one-cycle pulse at each frame start

## Operation
- phase counter runs 0..CLK_DIV-1, then wraps. On wrap, digit_idx increments, and NUM_DIGITS-1 wraps to 0.
- pwm_cnt (BRIGHT_W bits) free-runs +1 every clk.
- Staging: while load=1, staging is written with value/dp_in and pending is set to 1. Repeated loads overwrite staging.
- Frame boundary is the cycle in which digit_idx becomes 0 and phase becomes 0.
  - At the boundary, if pending=1: shadow ← staging, pending ← 0.
  - If load=1 in the same cycle: shadow ← the current value/dp_in directly and pending ← 0.
- Display uses shadow only. No mid-frame change is possible.
- Leading-zero suppression, when blank_lz=1:
  - Digit d is blanked if shadow nibbles NUM_DIGITS-1..d are all zero and d ≠ 0.
  - A blanked digit has segments off; dp still follows shadow dp.
- Hex decode (bits 6:0): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E.
- Anode bit d is low iff all of the following hold:
  - digit_idx==d
  - digit_en[d]=1
  - phase ≥ DEAD_CYCLES
  - pwm_cnt ≤ brightness
- The cathode always carries the decode of the current digit, independent of anode gating.

## Timing
- Reset values: sseg_anode all ones, sseg_cathode 8'hFF, digit_idx 0, frame_tick 0, phase 0, pwm_cnt 0, shadow/staging 0, pending 0.
- Reset is asynchronous. Assertion at any point, including mid-slot or mid-load, forces reset values immediately without a clock edge.
- The first slot after release is digit 0 with shadow 0.
- sseg_anode and sseg_cathode are registered. The value at cycle t+1 reflects the phase, digit_idx, pwm_cnt, shadow, digit_en and brightness of cycle t.
- digit_idx and frame_tick are registered state. frame_tick=1 exactly in the cycle where digit_idx==0 and phase==0, excluding the first cycle after reset.
- Slot length is exactly CLK_DIV cycles. Frame length is NUM_DIGITS*CLK_DIV cycles.
- A load takes effect at the next frame boundary, or at the same boundary if load is asserted in the boundary cycle.
- With brightness all-ones, anodes stay active for every non-dead cycle of the slot.

## Test plan
Bench parameters: NUM_DIGITS=4, CLK_DIV=8, DEAD_CYCLES=2, BRIGHT_W=2.
- Reset, then hold 40 cycles -> first cycle: anode 4'hF, cathode FF. Then digit 0 shows cathode C0. frame_tick pulses every 32 cycles; digit_idx steps every 8.
- load value 16'h3A5F, dp_in 0, brightness 3, digit_en 4'hF, blank_lz 0 -> from the next frame: slot 0 anode 1110 with cathode 8E, slot 1 with 92, slot 2 with 88, slot 3 with B0. Anode is low for 6 of every 8 slot cycles (registered, offset 1).
- load mid-frame -> cathodes are unchanged until frame_tick, then the new digits appear. load in the boundary cycle -> the new value is shown in that same frame.
- blank_lz=1, value 16'h0050 -> digits 3 and 2 give cathode FF, digit 1 gives 92, digit 0 gives C0. Value 16'h0000 -> only digit 0 shows C0. dp_in 4'b1000 with value 0 -> digit 3 cathode 7F.
- brightness 1 -> in active phase, anode is low only when pwm_cnt is 0 or 1 (50 %). digit_en[2]=0 -> anode bit 2 is never low. dp_in[1]=1 -> cathode bit 7 is 0 in slot 1.
- Assert reset mid-slot between clock edges -> anode F, cathode FF, digit_idx 0, pending cleared. After release, the display shows 0 until a new load.
